fc_frame_sched: RTL and testbench

- Frame-level scheduler for the fully connected accumulator stage of the digit classifier.
- Gates the 3-channel pooled feature stream into the accumulator in groups of BEATS beats per output neuron, and counts NUM_OUT neurons per frame.
- Captures each neuron score, runs a sequential argmax, and presents the winning class with a valid/ready handshake.
- Sits between the pooling output and the classification result interface.

---
 rtl/fc_frame_sched_if.sv | 39 +++
 rtl/fc_frame_sched.sv | 98 +++++++++
 tb/tb_fc_frame_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fc_frame_sched_if.sv
// fc_frame_sched_if: feature stream, accumulator and result handshake bundle.
// The scheduler connects through slave; the driving environment uses master.
interface fc_frame_sched_if #(
    parameter int DW    = 12,
    parameter int CLS_W = 4
);
    logic             start;
    logic             busy;
    logic             feat_valid;
    logic             feat_ready;
    logic [DW-1:0]    feat_in_1;
    logic [DW-1:0]    feat_in_2;
    logic [DW-1:0]    feat_in_3;
    logic             fc_valid_in;
    logic [DW-1:0]    fc_data_1;
    logic [DW-1:0]    fc_data_2;
    logic [DW-1:0]    fc_data_3;
    logic             fc_valid_out;
    logic [DW-1:0]    fc_data_out;
    logic             result_valid;
    logic             result_ready;
    logic [CLS_W-1:0] result_class;
    logic [DW-1:0]    result_score;
    logic             err_unexpected;

    modport master (
        output start, feat_valid, feat_in_1, feat_in_2, feat_in_3,
               fc_valid_out, fc_data_out, result_ready,
        input  busy, feat_ready, fc_valid_in, fc_data_1, fc_data_2, fc_data_3,
               result_valid, result_class, result_score, err_unexpected
    );

    modport slave (
        input  start, feat_valid, feat_in_1, feat_in_2, feat_in_3,
               fc_valid_out, fc_data_out, result_ready,
        output busy, feat_ready, fc_valid_in, fc_data_1, fc_data_2, fc_data_3,
               result_valid, result_class, result_score, err_unexpected
    );
endinterface

// File: rtl/fc_frame_sched.sv
// fc_frame_sched: gates pooled features into the FC accumulator in per-neuron groups,
// captures the neuron scores and reports the argmax class over a valid/ready handshake.
module fc_frame_sched #(
    parameter int NUM_OUT = 10,
    parameter int BEATS   = 16,
    parameter int DW      = 12,
    parameter int CLS_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fc_frame_sched_if.slave bus
);
    localparam int BW = $clog2(NUM_OUT * BEATS + 1);
    localparam int RW = $clog2(NUM_OUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_OUT * BEATS - 1);
    localparam logic [RW-1:0] N_OUT     = RW'(NUM_OUT);
    localparam logic [RW-1:0] LAST_IDX  = RW'(NUM_OUT - 1);

    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, ARGMAX, DONE} state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [RW-1:0] res_idx;
    logic [RW-1:0] am_idx;
    logic [DW-1:0] score [NUM_OUT];
    logic          accept;
    logic          capture;

    assign bus.busy       = state != IDLE;
    assign bus.feat_ready = state == STREAM && beat_cnt <= LAST_BEAT;
    assign accept         = bus.feat_valid && bus.feat_ready;
    // Scores are only legal while the frame is streaming or draining and slots remain
    assign capture        = bus.fc_valid_out && (state == STREAM || state == DRAIN) && res_idx != N_OUT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            beat_cnt           <= '0;
            res_idx            <= '0;
            am_idx             <= '0;
            bus.fc_valid_in    <= 1'b0;
            bus.fc_data_1      <= '0;
            bus.fc_data_2      <= '0;
            bus.fc_data_3      <= '0;
            bus.result_valid   <= 1'b0;
            bus.result_class   <= '0;
            bus.result_score   <= '0;
            bus.err_unexpected <= 1'b0;
            for (int i = 0; i < NUM_OUT; i++) score[i] <= '0;
        end else begin
            bus.fc_valid_in <= accept;
            if (accept) begin
                bus.fc_data_1 <= bus.feat_in_1;
                bus.fc_data_2 <= bus.feat_in_2;
                bus.fc_data_3 <= bus.feat_in_3;
                beat_cnt      <= beat_cnt + 1'b1;
            end
            if (capture) begin
                score[res_idx] <= bus.fc_data_out;
                res_idx        <= res_idx + 1'b1;
            end else if (bus.fc_valid_out) begin
                bus.err_unexpected <= 1'b1;
            end
            case (state)
                IDLE:   if (bus.start) state <= STREAM;
                STREAM: if (accept && beat_cnt == LAST_BEAT) state <= DRAIN;
                DRAIN: begin
                    if (res_idx == N_OUT) begin
                        state  <= ARGMAX;
                        am_idx <= '0;
                    end
                end
                ARGMAX: begin
                    // Strictly-greater replace keeps ties on the lowest index
                    if (am_idx == '0 || $signed(score[am_idx]) > $signed(bus.result_score)) begin
                        bus.result_score <= score[am_idx];
                        bus.result_class <= CLS_W'(am_idx);
                    end
                    am_idx <= am_idx + 1'b1;
                    if (am_idx == LAST_IDX) begin
                        state            <= DONE;
                        bus.result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state            <= IDLE;
                        bus.result_valid <= 1'b0;
                        beat_cnt         <= '0;
                        res_idx          <= '0;
                        am_idx           <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_frame_sched.sv
// tb_fc_frame_sched: randomized frames against a frame-level reference model, with the
// bench acting as the group accumulator that returns a planned score per neuron.
module tb_fc_frame_sched;
    localparam int NUM_OUT = 10;
    localparam int BEATS   = 16;
    localparam int DW      = 12;
    localparam int CLS_W   = 4;
    localparam int TOTAL   = NUM_OUT * BEATS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inject = 1'b0;
    always #5 clk = ~clk;

    fc_frame_sched_if #(.DW(DW), .CLS_W(CLS_W)) bus ();

    fc_frame_sched #(.NUM_OUT(NUM_OUT), .BEATS(BEATS), .DW(DW), .CLS_W(CLS_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] sc [NUM_OUT];
    bit            m_busy, m_vin, m_err;
    int            m_beats, m_n, m_since;
    logic [DW-1:0] m_feat [3];
    logic [DW-1:0] m_sc [NUM_OUT];
    int            acc_cnt, acc_n, cnt_vin, cnt_vout;
    bit            pend, got;
    logic [CLS_W-1:0] got_class;
    logic [DW-1:0]    got_score;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_class();
        int b = 0;
        for (int i = 1; i < NUM_OUT; i++)
            if ($signed(m_sc[i]) > $signed(m_sc[b])) b = i;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare, accumulator behaviour and model advance all happen mid-cycle
    always @(negedge clk) begin
        bit acc, exp_valid;
        if (!rst_n) begin
            m_busy = 0; m_vin = 0; m_err = 0;
            m_beats = 0; m_n = 0; m_since = 0;
            for (int i = 0; i < 3; i++) m_feat[i] = '0;
            acc_cnt = 0; acc_n = 0; pend = 0;
        end
        exp_valid = m_busy && m_n == NUM_OUT && m_since > NUM_OUT;
        chk("busy", bus.busy, m_busy);
        chk("feat_ready", bus.feat_ready, m_busy && m_beats < TOTAL);
        chk("fc_valid_in", bus.fc_valid_in, m_vin);
        chk("fc_data_1", bus.fc_data_1, m_feat[0]);
        chk("fc_data_2", bus.fc_data_2, m_feat[1]);
        chk("fc_data_3", bus.fc_data_3, m_feat[2]);
        chk("result_valid", bus.result_valid, exp_valid);
        chk("err_unexpected", bus.err_unexpected, m_err);
        if (exp_valid) begin
            chk("result_class", bus.result_class, exp_class());
            chk("result_score", bus.result_score, m_sc[exp_class()]);
            if (!got) begin
                got = 1;
                got_class = bus.result_class;
                got_score = bus.result_score;
            end
        end
        if (!rst_n) begin
            bus.fc_valid_out = 1'b0;
            bus.fc_data_out  = '0;
        end else begin
            if (bus.fc_valid_in) cnt_vin++;
            bus.fc_valid_out = pend || inject;
            bus.fc_data_out  = pend ? sc[acc_n] : DW'($urandom);
            if (pend) acc_n++;
            pend = 0;
            if (bus.fc_valid_in && ++acc_cnt == BEATS) begin
                acc_cnt = 0;
                pend = 1;
            end
            if (bus.fc_valid_out) cnt_vout++;
            acc = m_busy && m_beats < TOTAL && bus.feat_valid;
            m_vin = acc;
            if (acc) begin
                m_feat[0] = bus.feat_in_1;
                m_feat[1] = bus.feat_in_2;
                m_feat[2] = bus.feat_in_3;
                m_beats++;
            end
            if (bus.fc_valid_out) begin
                if (!m_busy || m_n == NUM_OUT) m_err = 1;
                else begin
                    m_sc[m_n] = bus.fc_data_out;
                    m_n++;
                    m_since = 0;
                end
            end else if (m_n == NUM_OUT) begin
                m_since++;
            end
            if (!m_busy && bus.start) begin
                m_busy = 1;
                got = 0; cnt_vin = 0; cnt_vout = 0; acc_n = 0; acc_cnt = 0;
            end else if (exp_valid && bus.result_ready) begin
                m_busy = 0; m_beats = 0; m_n = 0; m_since = 0;
            end
        end
    end

    // mode 0: feat_valid toggles 1,0,...; 1: random; 2: always high.
    // hold: cycles result_ready stays low once a result is up; abort_at: beats before reset.
    task automatic run_frame(input int mode, input int hold, input int abort_at);
        int waited = 0;
        bit v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 4000 && m_busy; cyc++) begin
            if (abort_at > 0 && m_beats >= abort_at) begin
                bus.feat_valid = 1'b0;
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            v = m_busy && m_n == NUM_OUT && m_since > NUM_OUT;
            bus.feat_valid = mode == 0 ? cyc % 2 == 0 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.feat_in_1 = DW'($urandom);
            bus.feat_in_2 = DW'($urandom);
            bus.feat_in_3 = DW'($urandom);
            if (v) waited++;
            bus.result_ready = v && waited > hold;
            bus.start = v && $urandom_range(0, 3) == 0;
            tick();
        end
        bus.start = 1'b0;
        bus.feat_valid = 1'b0;
        bus.result_ready = 1'b0;
        if (m_busy) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: frame still busy after 4000 cycles at %0t", $time);
        end
    endtask

    initial begin
        int tab_a [NUM_OUT] = '{5, -3, 40, 7, 40, 0, 1, 2, 3, -100};
        bus.start = 0; bus.feat_valid = 0; bus.result_ready = 0;
        bus.feat_in_1 = '0; bus.feat_in_2 = '0; bus.feat_in_3 = '0;
        for (int i = 0; i < NUM_OUT; i++) sc[i] = '0;
        repeat (3) tick();
        chk("rst_class", bus.result_class, 0);
        chk("rst_score", bus.result_score, 0);
        chk("rst_err", bus.err_unexpected, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NUM_OUT; i++) sc[i] = DW'(tab_a[i]);
        run_frame(0, 0, 0);
        chk("tie_class", got_class, 2);
        chk("tie_score", got_score, 40);
        chk("vin_pulses", cnt_vin, TOTAL);
        chk("vout_pulses", cnt_vout, NUM_OUT);

        for (int i = 0; i < NUM_OUT; i++) sc[i] = DW'(-(i + 1));
        run_frame(1, 20, 0);
        chk("neg_class", got_class, 0);
        chk("neg_score", got_score, 12'hFFF);

        for (int i = 0; i < NUM_OUT; i++) sc[i] = DW'($urandom_range(0, 500));
        sc[2] = 12'd2000;
        run_frame(2, 0, 70);
        for (int i = 0; i < NUM_OUT; i++) sc[i] = DW'($urandom_range(0, 500));
        sc[7] = 12'd1000;
        run_frame(1, 3, 0);
        chk("abort_class", got_class, 7);
        chk("abort_score", got_score, 1000);

        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        chk("inject_err", bus.err_unexpected, 1);
        for (int i = 0; i < NUM_OUT; i++) sc[i] = DW'(i * 3);
        sc[4] = 12'd900;
        run_frame(2, 1, 0);
        chk("post_err_class", got_class, 4);
        chk("err_sticky", bus.err_unexpected, 1);

        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < NUM_OUT; i++) sc[i] = DW'($urandom);
            run_frame($urandom_range(0, 2), $urandom_range(0, 6), 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
